// File: rtl/alu_sync.sv
// alu_sync: 8-bit synchronous ALU with a start/done handshake.
// Operands and opcode are latched on a start request in IDLE; single-cycle
// ops complete one edge later (EXEC), while MUL/DIV/MOD run an 8-step
// iterative datapath (ITER) when ALU_MULDIV_EN is defined. Without that
// macro the iterative datapath is absent and 0A/0B/0C return 00 in one cycle.
// result only changes on the completion edge; alu_done is high in IDLE.

module alu_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [5:0] op,
  output logic [7:0] result,
  output logic       alu_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_XOR  = 6'h04;
  localparam logic [5:0] OP_NOT  = 6'h05;
  localparam logic [5:0] OP_SHL  = 6'h06;
  localparam logic [5:0] OP_SHR  = 6'h07;
  localparam logic [5:0] OP_INC  = 6'h08;
  localparam logic [5:0] OP_DEC  = 6'h09;
  localparam logic [5:0] OP_PASS = 6'h0D;
`ifdef ALU_MULDIV_EN
  localparam logic [5:0] OP_MUL  = 6'h0A;
  localparam logic [5:0] OP_DIV  = 6'h0B;
  localparam logic [5:0] OP_MOD  = 6'h0C;
`endif

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [5:0] r_op;
  logic [7:0] r_result;
  logic [7:0] w_exec_result;
  logic       w_is_muldiv;

`ifdef ALU_MULDIV_EN
  // Iterative datapath. r_acc is the product accumulator (MUL) or the partial
  // remainder (DIV/MOD); r_x is the shifting multiplicand (MUL) or the
  // dividend/quotient shift register (DIV/MOD); r_y is the shifting multiplier.
  logic [2:0] r_cnt;
  logic [7:0] r_acc;
  logic [7:0] r_x;
  logic [7:0] r_y;
  logic       w_last;
  logic [7:0] w_mul_acc;
  logic [8:0] w_shift;
  logic       w_ge;
  logic [7:0] w_rem_next;
  logic [7:0] w_quo_next;
  logic [7:0] w_iter_result;

  assign w_is_muldiv = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  assign w_last      = (r_cnt == 3'd7);

  // Shift-add multiply step: add the multiplicand when the multiplier LSB is set.
  assign w_mul_acc   = r_y[0] ? (r_acc + r_x) : r_acc;

  // Restoring divide step: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits. A zero divisor always "fits", which
  // yields quotient FF and remainder a without any special case.
  assign w_shift     = {r_acc, r_x[7]};
  assign w_ge        = (w_shift >= {1'b0, r_b});
  assign w_rem_next  = w_ge ? (w_shift[7:0] - r_b) : w_shift[7:0];
  assign w_quo_next  = {r_x[6:0], w_ge};

  assign w_iter_result = (r_op == OP_MUL) ? w_mul_acc  :
                         (r_op == OP_DIV) ? w_quo_next : w_rem_next;
`else
  assign w_is_muldiv = 1'b0;
`endif

  assign result   = r_result;
  assign alu_done = (r_state == ST_IDLE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic: start only from IDLE, single-cycle ops go through EXEC.
  always_comb begin
    // NOTE: default first so no path through this block leaves a latch.
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (alu_start) w_next_state = w_is_muldiv ? ST_ITER : ST_EXEC;
      end
      ST_EXEC: w_next_state = ST_IDLE;
      ST_ITER: begin
`ifdef ALU_MULDIV_EN
        if (w_last) w_next_state = ST_IDLE;
`else
        w_next_state = ST_IDLE;
`endif
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Operand latch: captured only on an accepted start, frozen while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a  <= 8'h00;
      r_b  <= 8'h00;
      r_op <= 6'h00;
    end else if (r_state == ST_IDLE && alu_start) begin
      r_a  <= a;
      r_b  <= b;
      r_op <= op;
    end
  end

  // Single-cycle result from the latched operands; unknown opcodes give 00.
  always_comb begin
    w_exec_result = 8'h00;
    case (r_op)
      OP_ADD:  w_exec_result = r_a + r_b;
      OP_SUB:  w_exec_result = r_a - r_b;
      OP_AND:  w_exec_result = r_a & r_b;
      OP_OR:   w_exec_result = r_a | r_b;
      OP_XOR:  w_exec_result = r_a ^ r_b;
      OP_NOT:  w_exec_result = ~r_a;
      OP_SHL:  w_exec_result = {r_a[6:0], 1'b0};
      OP_SHR:  w_exec_result = {1'b0, r_a[7:1]};
      OP_INC:  w_exec_result = r_a + 8'd1;
      OP_DEC:  w_exec_result = r_a - 8'd1;
      OP_PASS: w_exec_result = r_a;
      default: w_exec_result = 8'h00;
    endcase
  end

`ifdef ALU_MULDIV_EN
  // Iteration registers: seeded from the live inputs on start, stepped in ITER.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 3'd0;
      r_acc <= 8'h00;
      r_x   <= 8'h00;
      r_y   <= 8'h00;
    end else if (r_state == ST_IDLE && alu_start) begin
      r_cnt <= 3'd0;
      r_acc <= 8'h00;
      r_x   <= a;
      r_y   <= b;
    end else if (r_state == ST_ITER) begin
      r_cnt <= r_cnt + 3'd1;
      if (r_op == OP_MUL) begin
        r_acc <= w_mul_acc;
        r_x   <= {r_x[6:0], 1'b0};
        r_y   <= {1'b0, r_y[7:1]};
      end else begin
        r_acc <= w_rem_next;
        r_x   <= w_quo_next;
      end
    end
  end
`endif

  // Result register: written only on the completion edge of an operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= 8'h00;
    end else if (r_state == ST_EXEC) begin
      r_result <= w_exec_result;
`ifdef ALU_MULDIV_EN
    end else if (r_state == ST_ITER && w_last) begin
      r_result <= w_iter_result;
`endif
    end
  end

endmodule

// File: tb/tb_alu_sync.sv
// tb_alu_sync: scoreboard bench for alu_sync. Expected results and latencies
// are queued when an operation is driven and compared when alu_done rises.
// Works for both builds; define ALU_MULDIV_EN for bench and RTL together.

module tb_alu_sync;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_start;
  logic [7:0] a;
  logic [7:0] b;
  logic [5:0] op;
  logic [7:0] result;
  logic       alu_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         lat_q[$];

  alu_sync dut (
    .clk       (clk),
    .reset     (reset),
    .alu_start (alu_start),
    .a         (a),
    .b         (b),
    .op        (op),
    .result    (result),
    .alu_done  (alu_done)
  );

  always #5 clk = ~clk;

  // Reference model of the opcode table.
  function automatic logic [7:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic [5:0] mop);
    logic [15:0] p;
    p = 16'h0000;
    case (mop)
      6'h00: return ma + mb;
      6'h01: return ma - mb;
      6'h02: return ma & mb;
      6'h03: return ma | mb;
      6'h04: return ma ^ mb;
      6'h05: return ~ma;
      6'h06: return ma << 1;
      6'h07: return ma >> 1;
      6'h08: return ma + 8'd1;
      6'h09: return ma - 8'd1;
`ifdef ALU_MULDIV_EN
      6'h0A: begin p = 16'(ma) * 16'(mb); return p[7:0]; end
      6'h0B: return (mb == 8'h00) ? 8'hFF : ma / mb;
      6'h0C: return (mb == 8'h00) ? ma : ma % mb;
`endif
      6'h0D: return ma;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int model_lat(input logic [5:0] mop);
`ifdef ALU_MULDIV_EN
    if (mop == 6'h0A || mop == 6'h0B || mop == 6'h0C) return 8;
`endif
    return 1;
  endfunction

  // Drive one start request at the negedge, push its expectation, and return
  // #1 after the capturing edge. hold keeps alu_start asserted afterwards.
  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v, input logic [5:0] top,
                       input logic [7:0] texp, input logic hold);
    @(negedge clk);
    a = ta; b = tb_v; op = top; alu_start = 1'b1;
    exp_q.push_back(texp);
    lat_q.push_back(model_lat(top));
    @(posedge clk); #1;
    if (!hold) alu_start = 1'b0;
  endtask

  // Count edges until alu_done rises (bounded), noting any result change
  // before the completion edge.
  task automatic wait_done(output int lat, output logic [7:0] res, output logic stable);
    logic [7:0] prev;
    prev   = result;
    lat    = 0;
    stable = 1'b1;
    while (!alu_done && lat < 40) begin
      if (result !== prev) stable = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic test_reset();
    int lat; logic [7:0] res; logic st; logic [7:0] e; int el;
    reset = 1'b1; alu_start = 1'b0; a = 8'h00; b = 8'h00; op = 6'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset result: got %h want 00", result); end
    checks++; if (alu_done !== 1'b1) begin errors++; $display("FAIL reset alu_done: got %b want 1", alu_done); end
    @(negedge clk); reset = 1'b0;
    issue(8'h05, 8'h03, 6'h00, 8'h08, 1'b0);
    checks++; if (alu_done !== 1'b0) begin errors++; $display("FAIL first_add busy: alu_done=%b want 0", alu_done); end
    wait_done(lat, res, st);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (lat !== el) begin errors++; $display("FAIL first_add latency: got %0d want %0d", lat, el); end
    checks++; if (res !== e) begin errors++; $display("FAIL first_add result: got %h want %h", res, e); end
  endtask

  task automatic test_single_cycle();
    logic [7:0] ta[14] = '{8'h03, 8'hF0, 8'h81, 8'h00, 8'h12, 8'hFF, 8'hC3, 8'hC0, 8'h5A, 8'h81, 8'hFF, 8'h7E, 8'h12, 8'h12};
    logic [7:0] tb_v[14] = '{8'h05, 8'h3C, 8'h00, 8'h00, 8'h34, 8'h01, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h99, 8'h34, 8'h34};
    logic [5:0] top[14] = '{6'h01, 6'h04, 6'h06, 6'h09, 6'h3F, 6'h00, 6'h02, 6'h03, 6'h05, 6'h07, 6'h08, 6'h0D, 6'h0E, 6'h20};
    logic [7:0] tex[14] = '{8'hFE, 8'hCC, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h03, 8'hCF, 8'hA5, 8'h40, 8'h00, 8'h7E, 8'h00, 8'h00};
    int lat; logic [7:0] res; logic st; logic [7:0] e; int el;
    for (int i = 0; i < 14; i++) begin
      issue(ta[i], tb_v[i], top[i], tex[i], 1'b0);
      checks++; if (alu_done !== 1'b0) begin errors++; $display("FAIL single[%0d] busy: alu_done=%b want 0", i, alu_done); end
      wait_done(lat, res, st);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      checks++; if (lat !== el) begin errors++; $display("FAIL single[%0d] latency: got %0d want %0d", i, lat, el); end
      checks++; if (res !== e) begin errors++; $display("FAIL single[%0d] op %h result: got %h want %h", i, top[i], res, e); end
    end
  endtask

  task automatic test_muldiv();
`ifdef ALU_MULDIV_EN
    logic [7:0] ta[8]  = '{8'h10, 8'h64, 8'h64, 8'h37, 8'h37, 8'hFF, 8'hFF, 8'h05};
    logic [7:0] tb_v[8] = '{8'h11, 8'h07, 8'h07, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h09};
    logic [5:0] top[8] = '{6'h0A, 6'h0B, 6'h0C, 6'h0B, 6'h0C, 6'h0A, 6'h0B, 6'h0C};
    logic [7:0] tex[8] = '{8'h10, 8'h0E, 8'h02, 8'hFF, 8'h37, 8'h01, 8'hFF, 8'h05};
    localparam int N = 8;
`else
    logic [7:0] ta[3]  = '{8'h03, 8'h64, 8'h64};
    logic [7:0] tb_v[3] = '{8'h04, 8'h07, 8'h07};
    logic [5:0] top[3] = '{6'h0A, 6'h0B, 6'h0C};
    logic [7:0] tex[3] = '{8'h00, 8'h00, 8'h00};
    localparam int N = 3;
`endif
    int lat; logic [7:0] res; logic st; logic [7:0] e; int el;
    for (int i = 0; i < N; i++) begin
      issue(ta[i], tb_v[i], top[i], tex[i], 1'b0);
      wait_done(lat, res, st);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      checks++; if (lat !== el) begin errors++; $display("FAIL muldiv[%0d] latency: got %0d want %0d", i, lat, el); end
      checks++; if (res !== e) begin errors++; $display("FAIL muldiv[%0d] op %h result: got %h want %h", i, top[i], res, e); end
      checks++; if (st !== 1'b1) begin errors++; $display("FAIL muldiv[%0d] intermediate result visible: stable=%b want 1", i, st); end
    end
  endtask

  task automatic test_busy();
    int lat; logic [7:0] res; logic st; logic [7:0] e; int el;
    issue(8'h10, 8'h11, 6'h0A, model(8'h10, 8'h11, 6'h0A), 1'b1);
    // New inputs while busy; they must only take effect for the next operation.
    a = 8'h22; b = 8'h33; op = 6'h00;
    exp_q.push_back(8'h55); lat_q.push_back(1);
    wait_done(lat, res, st);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (lat !== el) begin errors++; $display("FAIL busy first latency: got %0d want %0d", lat, el); end
    checks++; if (res !== e) begin errors++; $display("FAIL busy first result: got %h want %h", res, e); end
    @(posedge clk); #1;
    checks++; if (alu_done !== 1'b0) begin errors++; $display("FAIL busy restart: alu_done=%b want 0", alu_done); end
    alu_start = 1'b0;
    wait_done(lat, res, st);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (lat !== el) begin errors++; $display("FAIL busy second latency: got %0d want %0d", lat, el); end
    checks++; if (res !== e) begin errors++; $display("FAIL busy second result: got %h want %h", res, e); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [7:0] res; logic st; logic [7:0] e; int el;
    logic [7:0] ra, rb; logic [5:0] rop;
    ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255)); rop = 6'($urandom_range(0, 15));
    issue(ra, rb, rop, model(ra, rb, rop), 1'b1);
    for (int k = 0; k < 10; k++) begin
      wait_done(lat, res, st);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      checks++; if (lat !== el) begin errors++; $display("FAIL b2b[%0d] latency: got %0d want %0d", k, lat, el); end
      checks++; if (res !== e) begin errors++; $display("FAIL b2b[%0d] result: got %h want %h", k, res, e); end
      if (k < 9) begin
        ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 255));
        rop = 6'($urandom_range(0, 15));
        a = ra; b = rb; op = rop;
        exp_q.push_back(model(ra, rb, rop)); lat_q.push_back(model_lat(rop));
        @(posedge clk); #1;
        checks++; if (alu_done !== 1'b0) begin errors++; $display("FAIL b2b[%0d] restart: alu_done=%b want 0", k, alu_done); end
      end
    end
    alu_start = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [7:0] res; logic st; logic [7:0] e; int el; logic stale_ok;
    issue(8'h40, 8'h01, 6'h00, 8'h41, 1'b0);
    wait_done(lat, res, st);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (res !== e) begin errors++; $display("FAIL pre_abort result: got %h want %h", res, e); end
    issue(8'h64, 8'h07, 6'h0B, model(8'h64, 8'h07, 6'h0B), 1'b0);
`ifdef ALU_MULDIV_EN
    repeat (3) @(posedge clk);
`endif
    #2; reset = 1'b1; #1;
    exp_q.delete(); lat_q.delete();
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL abort result: got %h want 00", result); end
    checks++; if (alu_done !== 1'b1) begin errors++; $display("FAIL abort alu_done: got %b want 1", alu_done); end
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    stale_ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (result !== 8'h00 || alu_done !== 1'b1) stale_ok = 1'b0;
    end
    checks++; if (stale_ok !== 1'b1) begin errors++; $display("FAIL post_abort stale output: ok=%b want 1", stale_ok); end
    // Start held high across reset release is accepted on the first edge.
    @(negedge clk); reset = 1'b1; a = 8'h01; b = 8'h02; op = 6'h00; alu_start = 1'b1;
    @(negedge clk); reset = 1'b0;
    exp_q.push_back(8'h03); lat_q.push_back(1);
    @(posedge clk); #1;
    alu_start = 1'b0;
    checks++; if (alu_done !== 1'b0) begin errors++; $display("FAIL release_start busy: alu_done=%b want 0", alu_done); end
    wait_done(lat, res, st);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (lat !== el) begin errors++; $display("FAIL release_start latency: got %0d want %0d", lat, el); end
    checks++; if (res !== e) begin errors++; $display("FAIL release_start result: got %h want %h", res, e); end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_muldiv();
    test_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_sync.md
# alu_sync

Synchronous 8-bit ALU with a start/done handshake, driven by the microprocessor sequencer and clocked by the gated clock from `clock_gen`. Operands and opcode are captured on a start request. The result is produced after a fixed, opcode-dependent number of cycles and held until the next operation completes. `alu_done` doubles as a ready flag: the sequencer only issues the next instruction while it is high.

## Interface
- No parameters.
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `alu_start` input 1: start request, sampled on a rising edge while idle.
- `a` input 8: operand A.
- `b` input 8: operand B; ignored by single-operand ops.
- `op` input 6: operation code.
- `result` output 8: registered result of the last completed operation.
- `alu_done` output 1: high when idle/complete, low while an operation is executing.

## Operation
- States:
  - IDLE: `alu_done`=1.
  - EXEC: single-cycle ops.
  - ITER: multiply/divide.
- IDLE with `alu_start`=1 at an edge:
  - Latch `a`, `b`, `op`; drive `alu_done` to 0.
  - Go to ITER for MUL/DIV/MOD when `ALU_MULDIV_EN` is defined; otherwise go to EXEC.
- EXEC: next edge writes `result` from the latched operands, sets `alu_done`=1, returns to IDLE.
- ITER: shift-add multiply or restoring divide, one bit per cycle for 8 cycles. The final iteration edge writes `result`, sets `alu_done`=1, returns to IDLE.
- `alu_start` is ignored while not IDLE; input changes during execution have no effect.
- If `alu_start` is held high, a new operation begins on the first edge in IDLE, so back-to-back operations each spend at least one cycle with `alu_done`=1.
- Opcodes (hex). All arithmetic is modulo 256, unsigned, with no flags.
  - 00 ADD: a+b
  - 01 SUB: a−b
  - 02 AND, 03 OR, 04 XOR
  - 05 NOT a
  - 06 SHL a by 1, zero fill
  - 07 SHR a by 1, zero fill
  - 08 INC a, 09 DEC a
  - 0A MUL: low 8 bits of a×b
  - 0B DIV: a/b
  - 0C MOD: a%b
  - 0D PASS a
  - All other opcodes: result 00.
- Divide by zero: DIV gives FF, MOD gives a; the normal 8-cycle latency still applies.
- `result` changes only on completion; it never shows intermediate values.

## Timing
- Reset values: `result`=00, `alu_done`=1, state IDLE, latched operands 00.
- Start sampled at edge N: `alu_done`=0 after edge N.
  - Single-cycle op: `result` valid and `alu_done`=1 after edge N+1 (latency 1 cycle).
  - MUL/DIV/MOD: `result` valid and `alu_done`=1 after edge N+8 (latency 8 cycles).
- Reset asserted mid-operation: immediate abort, outputs return to reset values, and no stale result appears after release.
- `alu_start` high on the first edge after reset release starts an operation normally.

## Configuration
- `ALU_MULDIV_EN` defined: ops 0A/0B/0C are implemented with the iterative datapath and ITER state as specified.
- Not defined: the iterative datapath is removed; 0A/0B/0C behave as unsupported opcodes (result 00, single-cycle EXEC latency).

## Test plan
- Reset check: assert reset with `alu_start`=0 -> `result`=00, `alu_done`=1. Release, pulse start with op=00, a=0x05, b=0x03 -> `alu_done` low for 1 cycle, then `result`=0x08 with `alu_done`=1.
- Single-cycle ops:
  - SUB a=0x03, b=0x05 -> 0xFE
  - XOR 0xF0^0x3C -> 0xCC
  - SHL 0x81 -> 0x02
  - DEC 0x00 -> 0xFF
  - op=0x3F -> 0x00
- With `ALU_MULDIV_EN`:
  - MUL 0x10×0x11 -> 0x10 after exactly 8 cycles with `alu_done` low.
  - DIV 0x64/0x07 -> 0x0E; MOD -> 0x02.
  - DIV by 0 -> 0xFF; MOD by 0 -> a.
- Without `ALU_MULDIV_EN`: MUL 0x03×0x04 -> 0x00 with 1-cycle latency.
- Busy behaviour: start MUL, then change a/b/op and keep `alu_start` high during ITER -> first result is from the latched operands; the second operation begins on the first edge after `alu_done` rises.
- Reset mid-operation: assert reset during cycle 4 of a DIV -> `result`=00 and `alu_done`=1 immediately, before any clock edge.
